// File: rtl/pipe_pkg.sv
// Shared pipeline-register package: default widths and the control bundle layout
// carried by EX/MEM and MEM/WB elastic registers.
package pipe_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CTRL_W_DEF = 8;
    localparam int unsigned DEPTH_DEF  = 2;

    // Control bundle as seen by the back-end stages (8 bits, matches CTRL_W_DEF)
    typedef struct packed {
        logic       reg_wr;
        logic [1:0] wb_sel;
        logic       mem_wr;
        logic       mem_rd;
        logic [2:0] mem_size;
    } ctrl_t;

endpackage

// File: rtl/pipe_elastic_reg_if.sv
// Handshake bundle between an upstream stage, the elastic register and the
// downstream stage. master = stage/bench side, slave = elastic register side.
interface pipe_elastic_reg_if
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) ();

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic              flush;
    logic              stall;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [CNT_W-1:0]  count;

    modport master (
        output flush, stall, in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl, count
    );

    modport slave (
        input  flush, stall, in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl, count
    );

endinterface

// File: rtl/pipe_elastic_mem.sv
// Entry storage for the elastic register: one write port, one asynchronous read
// port. Contents are never reset; occupancy logic decides what is valid.
module pipe_elastic_mem #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 40
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Next storage image: overwrite the addressed entry on a write
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Storage array, no reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/pipe_elastic_reg.sv
// Elastic pipeline register: small FIFO between two pipeline stages with
// flush/stall control and a bubble-masked control bundle at the output.
// Optional build macro PIPE_STATS_EN adds saturating stall/bubble counters.
module pipe_elastic_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    pipe_elastic_reg_if.slave  bus
`ifdef PIPE_STATS_EN
    ,
    output logic [31:0]        stall_cycles,
    output logic [31:0]        bubble_cycles
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W = DATA_W + CTRL_W;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             in_ready_c;
    logic             out_valid_c;
    logic             push_c;
    logic             pop_c;
    logic [ENT_W-1:0] rd_entry;

    // Handshake qualifiers; flush and stall both suppress any transfer
    always_comb begin
        in_ready_c  = (count_q < CNT_W'(DEPTH)) && !bus.stall;
        out_valid_c = (count_q != '0);
        push_c      = bus.in_valid && in_ready_c && !bus.flush;
        pop_c       = out_valid_c && bus.out_ready && !bus.stall && !bus.flush;
    end

    // Next pointers and occupancy; flush wins over any push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    pipe_elastic_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_c && !rst),
        .wr_addr (wr_ptr_q),
        .wr_data ({bus.in_data, bus.in_ctrl}),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_entry)
    );

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.count     = count_q;
    assign bus.out_data  = rd_entry[ENT_W-1 -: DATA_W];
    // Bubbles must never carry live control bits downstream
    assign bus.out_ctrl  = out_valid_c ? rd_entry[CTRL_W-1:0] : '0;

`ifdef PIPE_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // Saturating stall/bubble counters, cleared by flush
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (bus.flush) begin
            stall_cnt_d  = '0;
            bubble_cnt_d = '0;
        end else begin
            if (bus.stall && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 32'(1);
            end
            if (!out_valid_c && !bus.stall && (bubble_cnt_q != '1)) begin
                bubble_cnt_d = bubble_cnt_q + 32'(1);
            end
        end
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cycles  = stall_cnt_q;
    assign bubble_cycles = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// Bench for pipe_elastic_reg: directed vector table on a DEPTH=2 instance,
// streaming and wrap sequences, and a randomized run on a DEPTH=4 instance
// against a queue model. Stats checks are compiled in with PIPE_STATS_EN.
module tb_pipe_elastic_reg;
    import pipe_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst2 = 1'b1;
    logic rst4 = 1'b1;

    pipe_elastic_reg_if #(.DATA_W(32), .CTRL_W(8), .DEPTH(2)) bus2 ();
    pipe_elastic_reg_if #(.DATA_W(32), .CTRL_W(8), .DEPTH(4)) bus4 ();

`ifdef PIPE_STATS_EN
    logic [31:0] st2, bb2, st4, bb4;
`endif

    pipe_elastic_reg #(.DATA_W(32), .CTRL_W(8), .DEPTH(2)) dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
`ifdef PIPE_STATS_EN
        , .stall_cycles (st2), .bubble_cycles (bb2)
`endif
    );

    pipe_elastic_reg #(.DATA_W(32), .CTRL_W(8), .DEPTH(4)) dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (bus4)
`ifdef PIPE_STATS_EN
        , .stall_cycles (st4), .bubble_cycles (bb4)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        flush;
        logic        stall;
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic [1:0]  cnt;
        logic        ov;
        logic [31:0] od;
        logic        ir;
    } vec_t;

    vec_t vt[$];

    task automatic add_v(input logic r, input logic f, input logic s, input logic iv,
                         input logic [31:0] id, input logic o, input logic [1:0] c,
                         input logic ov, input logic [31:0] od, input logic ir);
        vec_t v;
        v.rst = r; v.flush = f; v.stall = s; v.iv = iv; v.id = id; v.ordy = o;
        v.cnt = c; v.ov = ov; v.od = od; v.ir = ir;
        vt.push_back(v);
    endtask

    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  c;
    } ent_t;

    ent_t mq[$];

    task automatic idle2();
        bus2.flush = 0; bus2.stall = 0; bus2.in_valid = 0;
        bus2.in_data = '0; bus2.in_ctrl = '0; bus2.out_ready = 0;
    endtask

    task automatic idle4();
        bus4.flush = 0; bus4.stall = 0; bus4.in_valid = 0;
        bus4.in_data = '0; bus4.in_ctrl = '0; bus4.out_ready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] inq[$];
        logic [31:0] outq[$];
        int pushed;
        logic r_rst, r_fl, r_st, r_iv, r_or, exp_ir, pu, po;
        logic [31:0] r_d;
        logic [7:0]  r_c;

        idle2();
        idle4();

        //    rst flu stl iv  data          ordy cnt ov  out_data      in_ready
        add_v(1, 0, 0, 1, 32'h1000_00A0, 0, 0, 0, 32'h0,         1);
        add_v(1, 0, 0, 1, 32'h1000_00A0, 0, 0, 0, 32'h0,         1);
        add_v(0, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0,         1);
        add_v(0, 0, 0, 1, 32'h1000_00A1, 0, 1, 1, 32'h1000_00A1, 1);
        add_v(0, 0, 0, 1, 32'h1000_00A2, 0, 2, 1, 32'h1000_00A1, 0);
        add_v(0, 0, 0, 1, 32'h1000_00A3, 0, 2, 1, 32'h1000_00A1, 0);
        add_v(0, 0, 0, 1, 32'h1000_00A3, 1, 1, 1, 32'h1000_00A2, 1);
        add_v(0, 0, 0, 0, 32'h0,         1, 0, 0, 32'h0,         1);
        add_v(0, 0, 0, 1, 32'h2000_00B1, 0, 1, 1, 32'h2000_00B1, 1);
        add_v(0, 0, 0, 1, 32'h2000_00B2, 0, 2, 1, 32'h2000_00B1, 0);
        add_v(0, 0, 1, 1, 32'h2000_00B3, 1, 2, 1, 32'h2000_00B1, 0);
        add_v(0, 1, 1, 1, 32'h2000_00B3, 1, 0, 0, 32'h0,         0);
        add_v(0, 1, 0, 1, 32'h3000_00C1, 0, 0, 0, 32'h0,         1);
        add_v(0, 0, 0, 1, 32'h3000_00C2, 1, 1, 1, 32'h3000_00C2, 1);
        add_v(0, 0, 0, 0, 32'h0,         1, 0, 0, 32'h0,         1);
        add_v(0, 0, 0, 1, 32'h4000_00D1, 0, 1, 1, 32'h4000_00D1, 1);
        add_v(1, 0, 0, 1, 32'h4000_00D2, 0, 0, 0, 32'h0,         1);
        add_v(0, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0,         1);
        add_v(0, 0, 0, 1, 32'h5000_00E1, 0, 1, 1, 32'h5000_00E1, 1);
        add_v(0, 0, 0, 1, 32'h5000_00E2, 1, 1, 1, 32'h5000_00E2, 1);
        add_v(0, 0, 0, 0, 32'h0,         1, 0, 0, 32'h0,         1);

        // Directed vector table on the DEPTH=2 instance
        for (int i = 0; i < vt.size(); i++) begin
            rst2           = vt[i].rst;
            bus2.flush     = vt[i].flush;
            bus2.stall     = vt[i].stall;
            bus2.in_valid  = vt[i].iv;
            bus2.in_data   = vt[i].id;
            bus2.in_ctrl   = vt[i].id[7:0];
            bus2.out_ready = vt[i].ordy;
            @(posedge clk); #1;
            chk($sformatf("v%0d_count", i), 32'(bus2.count), 32'(vt[i].cnt));
            chk($sformatf("v%0d_out_valid", i), 32'(bus2.out_valid), 32'(vt[i].ov));
            chk($sformatf("v%0d_out_ctrl", i), 32'(bus2.out_ctrl),
                vt[i].ov ? 32'(vt[i].od[7:0]) : 32'h0);
            chk($sformatf("v%0d_in_ready", i), 32'(bus2.in_ready), 32'(vt[i].ir));
            if (vt[i].ov) begin
                chk($sformatf("v%0d_out_data", i), bus2.out_data, vt[i].od);
            end
        end
        rst2 = 0;
        idle2();

        // Streaming: one entry in and out per cycle
        for (int k = 0; k < 20; k++) begin
            bus2.in_valid  = 1;
            bus2.in_data   = 32'h0000_5500 + 32'(k);
            bus2.in_ctrl   = 8'(k + 1);
            bus2.out_ready = 1;
            @(posedge clk); #1;
            chk($sformatf("stream%0d_count", k), 32'(bus2.count), 32'd1);
            chk($sformatf("stream%0d_data", k), bus2.out_data, 32'h0000_5500 + 32'(k));
            chk($sformatf("stream%0d_ctrl", k), 32'(bus2.out_ctrl), 32'(8'(k + 1)));
        end
        bus2.in_valid = 0;
        @(posedge clk); #1;
        chk("stream_drain_count", 32'(bus2.count), 32'd0);
        idle2();

        // Bring DEPTH=4 instance out of reset
        @(posedge clk); #1;
        rst4 = 0;
        @(posedge clk); #1;
        chk("d4_reset_count", 32'(bus4.count), 32'd0);
        chk("d4_reset_in_ready", 32'(bus4.in_ready), 32'd1);
        chk("d4_reset_out_ctrl", 32'(bus4.out_ctrl), 32'd0);

        // Wrap: 9 entries through DEPTH=4 with random out_ready
        pushed = 0;
        for (int c = 0; c < 200 && outq.size() < 9; c++) begin
            bus4.in_valid  = (pushed < 9);
            bus4.in_data   = 32'hC0DE_0000 + 32'(pushed);
            bus4.in_ctrl   = 8'(pushed);
            bus4.out_ready = 1'($urandom_range(0, 1));
            #1;
            if (bus4.out_valid && bus4.out_ready) outq.push_back(bus4.out_data);
            if (bus4.in_valid && bus4.in_ready) begin
                inq.push_back(bus4.in_data);
                pushed++;
            end
            @(posedge clk); #1;
        end
        chk("wrap_out_count", 32'(outq.size()), 32'd9);
        for (int i = 0; i < outq.size() && i < 9; i++) begin
            chk($sformatf("wrap_item%0d", i), outq[i], 32'hC0DE_0000 + 32'(i));
        end
        idle4();
        @(posedge clk); #1;

        // Randomized run against a queue model
        mq.delete();
        rst4 = 1;
        @(posedge clk); #1;
        for (int c = 0; c < 400; c++) begin
            r_rst = ($urandom_range(0, 49) == 0);
            r_fl  = ($urandom_range(0, 19) == 0);
            r_st  = ($urandom_range(0, 5) == 0);
            r_iv  = ($urandom_range(0, 3) != 0);
            r_or  = ($urandom_range(0, 2) != 0);
            r_d   = $urandom;
            r_c   = 8'($urandom);
            rst4           = r_rst;
            bus4.flush     = r_fl;
            bus4.stall     = r_st;
            bus4.in_valid  = r_iv;
            bus4.in_data   = r_d;
            bus4.in_ctrl   = r_c;
            bus4.out_ready = r_or;
            #1;
            exp_ir = (mq.size() < 4) && !r_st;
            chk($sformatf("rnd%0d_in_ready", c), 32'(bus4.in_ready), 32'(exp_ir));
            if (r_rst || r_fl) begin
                mq.delete();
            end else begin
                pu = r_iv && exp_ir;
                po = (mq.size() > 0) && r_or && !r_st;
                if (po) void'(mq.pop_front());
                if (pu) mq.push_back({r_d, r_c});
            end
            @(posedge clk); #1;
            chk($sformatf("rnd%0d_count", c), 32'(bus4.count), 32'(mq.size()));
            chk($sformatf("rnd%0d_out_valid", c), 32'(bus4.out_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk($sformatf("rnd%0d_out_data", c), bus4.out_data, mq[0].d);
                chk($sformatf("rnd%0d_out_ctrl", c), 32'(bus4.out_ctrl), 32'(mq[0].c));
            end else begin
                chk($sformatf("rnd%0d_out_ctrl", c), 32'(bus4.out_ctrl), 32'd0);
            end
        end
        rst4 = 0;
        idle4();

`ifdef PIPE_STATS_EN
        // Stats: clear, 5 stall cycles, 3 empty cycles, then flush
        bus2.flush = 1;
        @(posedge clk); #1;
        bus2.flush = 0;
        bus2.stall = 1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        bus2.stall = 0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("stats_stall_cycles", st2, 32'd5);
        chk("stats_bubble_cycles", bb2, 32'd3);
        bus2.flush = 1;
        bus4.flush = 1;
        @(posedge clk); #1;
        chk("stats_stall_flushed", st2, 32'd0);
        chk("stats_bubble_flushed", bb2, 32'd0);
        chk("stats4_stall_flushed", st4, 32'd0);
        chk("stats4_bubble_flushed", bb4, 32'd0);
        idle2();
        idle4();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
